// File: rtl/riscv_types.sv
// Shared execute-stage types: ALU opcodes, divider state, and the writeback bundle.
package riscv_types;

    localparam int XLEN = 32;

    typedef enum logic [4:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_SLT,
        ALU_SLTU,
        ALU_MUL,
        DIV,
        DIVU,
        REM,
        REMU
    } alu_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        rd_we;
    } exe_p_mux_bus_type;

    localparam int          DIV_ITER       = 32;
    localparam logic [31:0] DIV_BY_ZERO_Q  = 32'hFFFF_FFFF;
    localparam logic [31:0] SIGNED_MIN     = 32'h8000_0000;
    localparam logic [31:0] NON_DIV_RESULT = 32'hDEAD_BEEF;

    function automatic logic is_div_op(input alu_t op);
        return (op == DIV) || (op == DIVU) || (op == REM) || (op == REMU);
    endfunction

    function automatic logic is_signed_op(input alu_t op);
        return (op == DIV) || (op == REM);
    endfunction

    function automatic logic is_rem_op(input alu_t op);
        return (op == REM) || (op == REMU);
    endfunction

endpackage

// File: rtl/int_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract D.
module int_div_step
    import riscv_types::*;
(
    input  logic [32:0] r,
    input  logic        dividend_bit,
    input  logic [31:0] d,
    output logic [32:0] r_next,
    output logic        q_bit
);

    logic [33:0] r_shift;
    logic [33:0] d_ext;
    logic [33:0] diff;

    // R never exceeds D after a step, so the top bit of r_shift is always zero.
    assign r_shift = {r, dividend_bit};
    assign d_ext   = {2'b00, d};
    assign diff    = r_shift - d_ext;
    assign q_bit   = (r_shift >= d_ext);
    assign r_next  = q_bit ? diff[32:0] : r_shift[32:0];

endmodule

// File: rtl/int_div.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU), radix-2 restoring, one bit per enabled clock.
//   state | meaning
//   IDLE  | waiting for p_start; special cases resolve straight to DONE
//   CALC  | one quotient bit per enabled edge, DIV_ITER iterations
//   DONE  | p_last high, result valid; back to IDLE on next enabled edge
module int_div
    import riscv_types::*;
#(
    parameter int XLEN_P = XLEN
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic              p_start,
    input  exe_p_mux_bus_type i_pipelined_signals,
    input  logic [31:0]       rs1,
    input  logic [31:0]       rs2,
    input  alu_t              alu_op,
    output exe_p_mux_bus_type o_pipelined_signals,
    output logic [4:0]        uu_rd,
    output logic              busy,
    output logic              p_last,
    output logic [31:0]       result
);

    localparam logic [5:0] LAST_CNT = 6'(DIV_ITER - 1);

    div_state_t        state_q, state_d;
    logic [5:0]        cnt_q;
    logic [32:0]       r_q;
    logic [31:0]       q_q;
    logic [31:0]       d_q;
    logic              neg_q_q;
    logic              neg_r_q;
    alu_t              op_q;
    exe_p_mux_bus_type bundle_q;
    logic [4:0]        rd_q;
    logic [31:0]       result_q;
    logic              p_last_q;

    logic              accept;
    logic              op_div;
    logic              op_signed;
    logic              by_zero;
    logic              overflow;
    logic              fast;
    logic [31:0]       fast_result;
    logic [31:0]       mag_a;
    logic [31:0]       mag_b;
    logic              last_iter;

    logic [32:0]       step_r;
    logic              step_q;
    logic [31:0]       q_fin;
    logic [31:0]       r_fin;
    logic [31:0]       final_result;

    int_div_step u_step (
        .r            (r_q),
        .dividend_bit (q_q[31]),
        .d            (d_q),
        .r_next       (step_r),
        .q_bit        (step_q)
    );

    assign op_div    = is_div_op(alu_op);
    assign op_signed = is_signed_op(alu_op);
    assign by_zero   = (rs2 == 32'd0);
    assign overflow  = op_signed && (rs1 == SIGNED_MIN) && (rs2 == 32'hFFFF_FFFF);
    assign fast      = !op_div || by_zero || overflow;
    assign accept    = en && p_start && (state_q == IDLE);
    assign last_iter = (cnt_q == LAST_CNT);

    // Two's-complement magnitude; SIGNED_MIN maps to itself, which is its correct unsigned magnitude.
    assign mag_a = (op_signed && rs1[31]) ? (32'd0 - rs1) : rs1;
    assign mag_b = (op_signed && rs2[31]) ? (32'd0 - rs2) : rs2;

    always_comb begin
        fast_result = NON_DIV_RESULT;
        if (op_div) begin
            if (by_zero) begin
                fast_result = is_rem_op(alu_op) ? rs1 : DIV_BY_ZERO_Q;
            end else if (overflow) begin
                fast_result = is_rem_op(alu_op) ? 32'd0 : SIGNED_MIN;
            end
        end
    end

    assign q_fin = {q_q[30:0], step_q};
    assign r_fin = step_r[31:0];

    always_comb begin
        final_result = neg_q_q ? (32'd0 - q_fin) : q_fin;
        if (is_rem_op(op_q)) begin
            final_result = neg_r_q ? (32'd0 - r_fin) : r_fin;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = fast ? DONE : CALC;
            CALC:    if (en && last_iter) state_d = DONE;
            DONE:    if (en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            r_q      <= '0;
            q_q      <= '0;
            d_q      <= '0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            op_q     <= alu_t'(0);
            bundle_q <= '0;
            rd_q     <= '0;
            result_q <= '0;
            p_last_q <= 1'b0;
        end else if (en) begin
            case (state_q)
                IDLE: begin
                    p_last_q <= 1'b0;
                    if (accept) begin
                        bundle_q <= i_pipelined_signals;
                        rd_q     <= i_pipelined_signals.rd;
                        op_q     <= alu_op;
                        neg_q_q  <= op_signed && (rs1[31] ^ rs2[31]);
                        neg_r_q  <= op_signed && rs1[31];
                        q_q      <= mag_a;
                        d_q      <= mag_b;
                        r_q      <= '0;
                        cnt_q    <= '0;
                        if (fast) begin
                            result_q <= fast_result;
                            p_last_q <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    r_q   <= step_r;
                    q_q   <= q_fin;
                    cnt_q <= cnt_q + 6'd1;
                    if (last_iter) begin
                        result_q <= final_result;
                        p_last_q <= 1'b1;
                    end
                end
                default: p_last_q <= 1'b0;
            endcase
        end
    end

    assign busy                = (state_q == CALC) || (state_q == DONE);
    assign p_last              = p_last_q;
    assign result              = result_q;
    assign uu_rd               = rd_q;
    assign o_pipelined_signals = bundle_q;

endmodule

// File: tb/tb_int_div.sv
// Scoreboard bench for int_div: driver pushes expected results, monitor checks on each completion pulse.
module tb_int_div;
    import riscv_types::*;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              en;
    logic              p_start;
    exe_p_mux_bus_type i_pipelined_signals;
    logic [31:0]       rs1;
    logic [31:0]       rs2;
    alu_t              alu_op;
    exe_p_mux_bus_type o_pipelined_signals;
    logic [4:0]        uu_rd;
    logic              busy;
    logic              p_last;
    logic [31:0]       result;

    int_div dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .en                  (en),
        .p_start             (p_start),
        .i_pipelined_signals (i_pipelined_signals),
        .rs1                 (rs1),
        .rs2                 (rs2),
        .alu_op              (alu_op),
        .o_pipelined_signals (o_pipelined_signals),
        .uu_rd               (uu_rd),
        .busy                (busy),
        .p_last              (p_last),
        .result              (result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0]       res;
        exe_p_mux_bus_type bun;
        int                cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model straight from the RV32M definitions.
    function automatic logic [31:0] ref_result(input alu_t op, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb_v;
        sa   = int'(a);
        sb_v = int'(b);
        case (op)
            DIV:  if (b == 0) return 32'hFFFF_FFFF;
                  else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                  else return 32'(sa / sb_v);
            REM:  if (b == 0) return a;
                  else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                  else return 32'(sa % sb_v);
            DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            REMU: return (b == 0) ? a : a % b;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic bit ref_fast(input alu_t op, input logic [31:0] a, input logic [31:0] b);
        if (!(op inside {DIV, DIVU, REM, REMU})) return 1'b1;
        if (b == 0) return 1'b1;
        return (op inside {DIV, REM}) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    endfunction

    // Monitor: compare on every rising p_last
    initial begin
        logic prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (p_last && !prev) begin
                if (sb.size() == 0) begin
                    chk("unexpected_p_last", 64'(result), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("result", 64'(result), 64'(e.res));
                    chk("bundle", 64'(o_pipelined_signals), 64'(e.bun));
                    chk("uu_rd", 64'(uu_rd), 64'(e.bun.rd));
                    chk("latency_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
            prev = p_last;
        end
    end

    // Completion lands 32 edges after the accept edge on the normal path (the 33rd cycle
    // counting the one after accept), on the very next cycle for special cases.
    task automatic run_op(input alu_t op, input logic [31:0] a, input logic [31:0] b,
                          input int freeze_at, input int freeze_len, input int done_hold,
                          input int rst_at, input bit poke);
        exe_p_mux_bus_type bun;
        exp_t e;
        bit   fast;
        int   acc, k, fz, busy_n, eff_freeze;
        bit   held;
        bun.pc    = $urandom;
        bun.rd    = 5'($urandom);
        bun.rd_we = 1'b1;
        fast       = ref_fast(op, a, b);
        eff_freeze = fast ? 0 : freeze_len;

        @(negedge clk);
        en = 1'b1; p_start = 1'b1; rs1 = a; rs2 = b; alu_op = op; i_pipelined_signals = bun;
        @(posedge clk);
        #1;
        acc = cyc;
        if (rst_at < 0) begin
            e.res = ref_result(op, a, b);
            e.bun = bun;
            e.cyc = acc + (fast ? 0 : DIV_ITER) + eff_freeze;
            sb.push_back(e);
        end
        k = 0; fz = 0; busy_n = 0; held = 1'b0;
        while (k < 300) begin
            @(negedge clk);
            k++;
            rs1 = $urandom; rs2 = $urandom;
            if (poke && k == 3) begin
                p_start = 1'b1; alu_op = DIVU; i_pipelined_signals = ~bun;
            end else begin
                p_start = 1'b0; alu_op = op; i_pipelined_signals = bun;
            end
            if (rst_at == k) begin
                reset_n = 1'b0;
                #1;
                chk("rst_busy", 64'(busy), 64'd0);
                chk("rst_p_last", 64'(p_last), 64'd0);
                chk("rst_result", 64'(result), 64'd0);
                chk("rst_uu_rd", 64'(uu_rd), 64'd0);
                chk("rst_bundle", 64'(o_pipelined_signals), 64'd0);
                @(negedge clk);
                reset_n = 1'b1;
                return;
            end
            if (!busy) break;
            busy_n++;
            if (p_last && done_hold > 0 && !held) begin
                held = 1'b1;
                en   = 1'b0;
                repeat (done_hold) begin
                    @(negedge clk);
                    chk("p_last_held", 64'(p_last), 64'd1);
                    busy_n++;
                end
                en = 1'b1;
            end else if (!fast && k == freeze_at && freeze_len > 0) begin
                en = 1'b0;
                fz = freeze_len;
            end else if (fz > 0) begin
                fz--;
                if (fz == 0) en = 1'b1;
            end
        end
        chk("idle_reached", 64'(busy), 64'd0);
        chk("busy_cycles", 64'(busy_n), 64'((fast ? 1 : DIV_ITER + 1) + eff_freeze + done_hold));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        alu_t ops[4];
        ops[0] = DIV; ops[1] = DIVU; ops[2] = REM; ops[3] = REMU;

        reset_n = 1'b0; en = 1'b0; p_start = 1'b0;
        rs1 = '0; rs2 = '0; alu_op = ALU_ADD; i_pipelined_signals = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_p_last", 64'(p_last), 64'd0);
        chk("reset_result", 64'(result), 64'd0);
        chk("reset_uu_rd", 64'(uu_rd), 64'd0);
        reset_n = 1'b1;
        en      = 1'b1;

        run_op(DIV,  32'hFFFF_FFF9, 32'd2,  0, 0, 0, -1, 1'b0);
        run_op(REM,  32'hFFFF_FFF9, 32'd2,  0, 0, 0, -1, 1'b0);
        run_op(DIVU, 32'hFFFF_FFFF, 32'd16, 0, 0, 0, -1, 1'b0);
        run_op(REMU, 32'hFFFF_FFFF, 32'd16, 0, 0, 0, -1, 1'b0);
        foreach (ops[i]) run_op(ops[i], 32'd1234, 32'd0, 0, 0, 0, -1, 1'b0);
        run_op(DIV,  32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, -1, 1'b0);
        run_op(REM,  32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, -1, 1'b0);
        run_op(ALU_ADD, 32'd5, 32'd3, 0, 0, 0, -1, 1'b0);
        run_op(DIV,  32'd1000, 32'hFFFF_FFFD, 12, 5, 0, -1, 1'b0);
        run_op(DIVU, 32'd999,  32'd10, 0, 0, 0, -1, 1'b1);
        run_op(REM,  32'h8000_0001, 32'd7, 0, 0, 4, -1, 1'b0);
        run_op(DIV,  32'd1, 32'd0, 0, 0, 3, -1, 1'b0);
        run_op(DIV,  32'h1234_5678, 32'd3, 0, 0, 0, 10, 1'b0);
        run_op(DIVU, 32'd100, 32'd7, 0, 0, 0, -1, 1'b0);

        for (int n = 0; n < 40; n++) begin
            alu_t        op;
            logic [31:0] a, b;
            int          sel;
            op  = ops[$urandom_range(0, 3)];
            a   = $urandom;
            b   = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 255)) : $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) b = 32'd0;
            if (sel == 1) begin
                op = ($urandom_range(0, 1) == 0) ? DIV : REM;
                a  = 32'h8000_0000;
                b  = 32'hFFFF_FFFF;
            end
            if (sel == 2) begin
                op = ALU_MUL;
                b  = b | 32'd1;
            end
            if (sel == 3) a = -a;
            run_op(op, a, b,
                   (sel >= 7) ? $urandom_range(1, 30) : 0,
                   (sel >= 7) ? $urandom_range(1, 4) : 0,
                   (sel == 5) ? $urandom_range(1, 3) : 0,
                   -1, (sel == 6));
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
